// File: rtl/count_stream_monitor_pkg.sv
// Shared definitions for the counter-stream monitor: sample width, FSM states,
// event record layout and the next-value predictor.
package count_stream_monitor_pkg;

    localparam int              CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;
    localparam int              EVT_W   = 2 * CNT_W;

    typedef enum logic {
        ST_UNPRIMED = 1'b0,
        ST_TRACK    = 1'b1
    } state_e;

    // One logged discontinuity: the sample before it and the sample at it.
    typedef struct packed {
        logic [CNT_W-1:0] from_val;
        logic [CNT_W-1:0] to_val;
    } evt_t;

    // Expected next counter value; the 4-bit add wraps 15 -> 0 naturally.
    function automatic logic [CNT_W-1:0] predict_next(input logic [CNT_W-1:0] prev);
        return prev + 4'd1;
    endfunction

endpackage

// File: rtl/count_stream_monitor_sync_fifo.sv
// Show-ahead synchronous FIFO. Pointers carry one extra MSB so that equal
// indices can be told apart as empty (MSBs equal) or full (MSBs differ).
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer and storage values for the accepted push/pop.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
        mem_q <= mem_d;
    end

endmodule

// File: rtl/count_stream_monitor.sv
// Consumer of the modulo-16 counter stream. Predicts each sample as prev+1,
// logs discontinuities into an event FIFO, counts natural 15->0 wraps and
// flags samples whose zero flag disagrees with the value.
module count_stream_monitor
    import count_stream_monitor_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  number,
    input  logic              zero,
    input  logic              clr,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CNT_W-1:0]  evt_from,
    output logic [CNT_W-1:0]  evt_to,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              zero_err,
    output logic              ovf
);

    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
    localparam logic [WRAP_W-1:0] WRAP_ONE = 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  prev_q, prev_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              zero_err_q, zero_err_d;
    logic              ovf_q, ovf_d;

    logic              push;
    evt_t              push_evt;
    evt_t              head_evt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    assign pop       = evt_valid && evt_ready;
    assign evt_valid = !fifo_empty;
    // With nothing queued the head is meaningless; present zeros instead of stale storage.
    assign evt_from  = fifo_empty ? '0 : head_evt.from_val;
    assign evt_to    = fifo_empty ? '0 : head_evt.to_val;
    assign wrap_cnt  = wrap_cnt_q;
    assign zero_err  = zero_err_q;
    assign ovf       = ovf_q;

    // Next state: priming, prediction, event push, wrap count and sticky flags.
    always_comb begin
        state_d           = state_q;
        prev_d            = number;
        wrap_cnt_d        = wrap_cnt_q;
        zero_err_d        = zero_err_q;
        ovf_d             = ovf_q;
        push              = 1'b0;
        push_evt.from_val = prev_q;
        push_evt.to_val   = number;

        unique case (state_q)
            ST_UNPRIMED: begin
                state_d = ST_TRACK;
            end
            ST_TRACK: begin
                if (number != predict_next(prev_q)) begin
                    push = 1'b1;
                end else if (prev_q == CNT_MAX && wrap_cnt_q != WRAP_MAX) begin
                    wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
                end
            end
            default: state_d = ST_UNPRIMED;
        endcase

        if (zero != (number == '0)) begin
            zero_err_d = 1'b1;
        end
        // A push into a full FIFO survives only if the head leaves this cycle.
        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end
        if (clr) begin
            wrap_cnt_d = '0;
            zero_err_d = 1'b0;
            ovf_d      = 1'b0;
        end
    end

    // Monitor state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_UNPRIMED;
            prev_q     <= '0;
            wrap_cnt_q <= '0;
            zero_err_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            wrap_cnt_q <= wrap_cnt_d;
            zero_err_q <= zero_err_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_evt),
        .full  (fifo_full),
        .pop   (pop),
        .dout  (head_evt),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_count_stream_monitor.sv
// Directed bench for count_stream_monitor. Inputs change 1 ns after each
// rising edge and outputs are checked at that same point, away from the edge.
module tb_count_stream_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] number;
    logic       zero;
    logic       clr;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_from;
    logic [3:0] evt_to;
    logic [7:0] wrap_cnt;
    logic       zero_err;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    count_stream_monitor #(
        .DEPTH  (4),
        .WRAP_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .number    (number),
        .zero      (zero),
        .clr       (clr),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_from  (evt_from),
        .evt_to    (evt_to),
        .wrap_cnt  (wrap_cnt),
        .zero_err  (zero_err),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one sample for one clock; returns 1 ns after the sampling edge.
    task automatic drive(input logic [3:0] n, input logic zr, input logic rdy, input logic cl);
        number    = n;
        zero      = zr;
        evt_ready = rdy;
        clr       = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ok(input logic [3:0] n);
        drive(n, n == 4'd0, 1'b0, 1'b0);
    endtask

    // Drive 2..15,0,1 starting from prev=1: exactly one natural wrap.
    task automatic one_lap();
        for (int v = 2; v < 18; v++) drive_ok(4'(v));
    endtask

    task automatic check_head(input string tag, input int f, input int t);
        check({tag, "_valid"}, int'(evt_valid), 1);
        check({tag, "_from"}, int'(evt_from), f);
        check({tag, "_to"}, int'(evt_to), t);
    endtask

    initial begin
        rst_n     = 1'b0;
        number    = 4'd0;
        zero      = 1'b1;
        clr       = 1'b0;
        evt_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_valid", int'(evt_valid), 0);
        check("rst_from", int'(evt_from), 0);
        check("rst_to", int'(evt_to), 0);
        check("rst_wrap", int'(wrap_cnt), 0);
        check("rst_zerr", int'(zero_err), 0);
        check("rst_ovf", int'(ovf), 0);

        // 1: clean count 0..15,0,1 -> one wrap, no events
        rst_n = 1'b1;
        for (int v = 0; v < 18; v++) drive_ok(4'(v));
        check("t1_valid", int'(evt_valid), 0);
        check("t1_wrap", int'(wrap_cnt), 1);
        check("t1_zerr", int'(zero_err), 0);
        check("t1_ovf", int'(ovf), 0);

        // 2: 2,3,4,9 -> event {4,9}; head stable while not ready; pop
        drive_ok(4'd2);
        drive_ok(4'd3);
        drive_ok(4'd4);
        check("t2_pre_valid", int'(evt_valid), 0);
        drive_ok(4'd9);
        check_head("t2_evt", 4, 9);
        drive(4'd10, 1'b0, 1'b0, 1'b0);
        check_head("t2_hold", 4, 9);
        drive(4'd11, 1'b0, 1'b1, 1'b0);
        check("t2_popped", int'(evt_valid), 0);

        // 3: five jumps with ready low; fifth dropped
        drive_ok(4'd5);
        drive_ok(4'd1);
        drive_ok(4'd8);
        drive_ok(4'd14);
        check("t3_ovf_before", int'(ovf), 0);
        drive(4'd3, 1'b0, 1'b0, 1'b0);
        check("t3_ovf", int'(ovf), 1);
        check_head("t3_head", 11, 5);
        // Clear stickies on a match (FIFO still full, no push)
        drive(4'd4, 1'b0, 1'b0, 1'b1);
        check("t3_clr_ovf", int'(ovf), 0);
        check("t3_clr_wrap", int'(wrap_cnt), 0);
        // Jump {4,9} with a simultaneous pop while full
        drive(4'd9, 1'b0, 1'b1, 1'b0);
        check("t3_pp_ovf", int'(ovf), 0);
        check_head("t3_q0", 5, 1);
        drive(4'd10, 1'b0, 1'b1, 1'b0);
        check_head("t3_q1", 1, 8);
        drive(4'd11, 1'b0, 1'b1, 1'b0);
        check_head("t3_q2", 8, 14);
        drive(4'd12, 1'b0, 1'b1, 1'b0);
        check_head("t3_q3", 4, 9);
        drive(4'd13, 1'b0, 1'b1, 1'b0);
        check("t3_drained", int'(evt_valid), 0);

        // 4: bad zero flag on a wrap, sticky, clr, clr on a wrap
        drive_ok(4'd14);
        drive_ok(4'd15);
        drive(4'd0, 1'b0, 1'b0, 1'b0);
        check("t4_zerr", int'(zero_err), 1);
        check("t4_wrap", int'(wrap_cnt), 1);
        drive_ok(4'd1);
        check("t4_zerr_sticky", int'(zero_err), 1);
        drive(4'd2, 1'b0, 1'b0, 1'b1);
        check("t4_clr_zerr", int'(zero_err), 0);
        check("t4_clr_wrap", int'(wrap_cnt), 0);
        for (int v = 3; v < 16; v++) drive_ok(4'(v));
        drive(4'd0, 1'b1, 1'b0, 1'b1);
        check("t4_clr_on_wrap", int'(wrap_cnt), 0);
        drive_ok(4'd1);
        check("t4_after", int'(wrap_cnt), 0);
        check("t4_no_evt", int'(evt_valid), 0);

        // 5: saturate the wrap counter, then a 7->0 jump
        for (int k = 0; k < 255; k++) one_lap();
        check("t5_wrap255", int'(wrap_cnt), 255);
        one_lap();
        check("t5_wrap_sat", int'(wrap_cnt), 255);
        check("t5_no_evt", int'(evt_valid), 0);
        for (int v = 2; v < 8; v++) drive_ok(4'(v));
        drive_ok(4'd0);
        check_head("t5_jump0", 7, 0);
        check("t5_wrap_hold", int'(wrap_cnt), 255);
        drive_ok(4'd5);
        check_head("t5_q_head", 7, 0);

        // 6: asynchronous reset with two events queued
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", int'(evt_valid), 0);
        check("t6_rst_wrap", int'(wrap_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'd12, 1'b1, 1'b0, 1'b0);
        check("t6_first_valid", int'(evt_valid), 0);
        check("t6_unprimed_zerr", int'(zero_err), 1);
        drive_ok(4'd13);
        check("t6_second_valid", int'(evt_valid), 0);
        drive_ok(4'd14);
        check("t6_third_valid", int'(evt_valid), 0);
        check("t6_ovf", int'(ovf), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
